// File: rtl/mcp_pkg.sv
// Shared definitions for the multi-cycle-path (MCP) CDC endpoints.
package mcp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } mcp_rx_state_e;

    // A single flop never gives a metastable level time to resolve.
    localparam int MCP_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/mcp_bit_sync.sv
// Single-bit level synchronizer (flop chain). Shared by the receiver request
// path and the source-side acknowledge path.
module mcp_bit_sync
    import mcp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_dst,
    input  logic rst_dst,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < MCP_MIN_SYNC_STAGES) begin : g_stage_check
        $fatal(1, "mcp_bit_sync: SYNC_STAGES must be >= %0d", MCP_MIN_SYNC_STAGES);
    end

    logic [SYNC_STAGES-1:0] sync_p;

    // Shift the asynchronous level through the chain; the last flop is stable.
    always_ff @(posedge clk_dst or posedge rst_dst) begin
        if (rst_dst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/mcp_ack_receiver.sv
// Destination endpoint of the MCP CDC protocol with toggle acknowledge.
// Only the request toggle is synchronized; the data bus is sampled a settle
// window after the request edge is seen, then offered on valid/ready and
// released back to the source with an acknowledge toggle.
// Optional feature: define MCP_RX_EARLY_ACK_EN to toggle the acknowledge at
// capture instead of at the consumer handshake.
module mcp_ack_receiver
    import mcp_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk_dst,
    input  logic                  rst_dst,
    input  logic                  req_tog_async,
    input  logic [DATA_WIDTH-1:0] data_async,
    output logic                  ack_tog,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  err_protocol
);

    if (SYNC_STAGES < MCP_MIN_SYNC_STAGES || SETTLE_CYCLES < 1) begin : g_param_check
        $fatal(1, "mcp_ack_receiver: need SYNC_STAGES >= %0d and SETTLE_CYCLES >= 1",
               MCP_MIN_SYNC_STAGES);
    end

`ifdef MCP_RX_EARLY_ACK_EN
    localparam bit EARLY_ACK = 1'b1;
`else
    localparam bit EARLY_ACK = 1'b0;
`endif

    localparam int             CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    mcp_rx_state_e    state;
    logic             req_sync;
    logic             req_seen;
    logic             req_pend;
    logic [CNT_W-1:0] settle_cnt;
    logic             req_in_flight;

    mcp_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_dst (clk_dst),
        .rst_dst (rst_dst),
        .d       (req_tog_async),
        .q       (req_sync)
    );

    assign req_pend = (req_sync != req_seen);

    // A new request edge is only illegal while the source has not yet been
    // released; with early ack the source is already free once in HOLD.
    assign req_in_flight = (state == SETTLE) || ((state == HOLD) && !EARLY_ACK);

    assign busy = (state != IDLE);

    // Receive FSM: detect request, wait out the settle window, capture, hand off.
    always_ff @(posedge clk_dst or posedge rst_dst) begin
        if (rst_dst) begin
            state        <= IDLE;
            req_seen     <= 1'b0;
            settle_cnt   <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            ack_tog      <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            // Sticky: the extra edge is still served later from IDLE.
            if (req_pend && req_in_flight) begin
                err_protocol <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_pend) begin
                        req_seen   <= req_sync;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        data_out   <= data_async;
                        data_valid <= 1'b1;
                        if (EARLY_ACK) begin
                            ack_tog <= ~ack_tog;
                        end
                        state <= HOLD;
                    end
                end

                HOLD: begin
                    if (data_valid && data_ready) begin
                        data_valid <= 1'b0;
                        if (!EARLY_ACK) begin
                            ack_tog <= ~ack_tog;
                        end
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mcp_ack_receiver.md
# mcp_ack_receiver

Destination-domain endpoint of the multi-cycle-path (MCP) CDC protocol with toggle acknowledge. The source holds a wide data bus stable and toggles a request level. This block synchronizes only the request, waits a settle window, and samples the unsynchronized bus. It then presents the word downstream with a valid/ready handshake and toggles an acknowledge level back to the source. It sits at the receive side of every MCP crossing that needs backpressure and source release signalling.

## Interface
- DATA_WIDTH, 32, width of transferred word
- SYNC_STAGES, 2, flops in request synchronizer (legal ≥2)
- SETTLE_CYCLES, 1, extra dst cycles between detected request edge and data sample (legal ≥1)

- clk_dst  in  1  destination clock; the only clock
- rst_dst  in  1  reset, asynchronous assert, active-high
- req_tog_async  in  1  request toggle from source domain; unsynchronized
- data_async  in  DATA_WIDTH  source-held data; unsynchronized, MCP-constrained
- ack_tog  out  1  acknowledge toggle to source domain; registered, glitch-free
- data_out  out  DATA_WIDTH  captured word
- data_valid  out  1  data_out valid to consumer
- data_ready  in  1  consumer accepts when high with data_valid
- busy  out  1  high in any state other than IDLE
- err_protocol  out  1  sticky protocol-violation flag

## Operation
- Synchronizer: req_tog_async passes through SYNC_STAGES flops to req_sync. No synchronization of data_async.
- req_seen register: a new request is pending when req_sync != req_seen.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE, request pending: req_seen <= req_sync; settle counter <= 0; go to SETTLE.
- SETTLE: counter increments each cycle. When counter == SETTLE_CYCLES-1: data_out <= data_async, data_valid <= 1, go to HOLD.
- HOLD, data_valid && data_ready: data_valid <= 0, ack_tog <= ~ack_tog, go to IDLE.
- data_out holds its value until the next capture and does not change while data_valid is high.
- Protocol violation: req_sync != req_seen while in SETTLE or HOLD, before ack toggles. Response: err_protocol <= 1, held until reset. The FSM continues normally and the extra edge is served as the next request from IDLE.
- Simultaneous HOLD handshake and new pending request: return to IDLE. The request is detected on the following cycle; no request is dropped.
- Counter width: $clog2(SETTLE_CYCLES+1); no wrap in legal operation.
- Reset mid-operation: all state clears and any word in flight is lost. Both domains must reset together. If the source request level is 1 after a receiver-only reset, the block treats it as a new request; this is defined behaviour.

## Timing
- Reset values: ack_tog=0, data_out=0, data_valid=0, busy=0, err_protocol=0, sync flops=0, req_seen=0, state=IDLE.
- Request toggle at source → req_sync changes after SYNC_STAGES clk_dst edges (plus ≤1 edge of CDC uncertainty).
- Pending request seen in IDLE at edge N → data_valid high after edge N+SETTLE_CYCLES+1.
- Default params: 2 to 3 sync edges + 2 edges to valid.
- ack_tog toggles on the handshake edge.
- Minimum per-word occupancy: SETTLE_CYCLES+2 cycles with ready held high.
- Source contract: data_async is stable from its req toggle until it observes the ack toggle.

## Configuration
- MCP_RX_EARLY_ACK_EN defined:
  - ack_tog toggles on the capture edge (SETTLE→HOLD), so the source is released before the consumer accepts.
  - A request arriving in HOLD after that ack is legal, does not set err_protocol, and stays pending until IDLE.
- Undefined: ack_tog toggles only on the consumer handshake, as in Operation.

## Structure
- Package mcp_pkg: mcp_rx_state_e enum {IDLE, SETTLE, HOLD}; constant MCP_MIN_SYNC_STAGES = 2.
- Sub-module mcp_bit_sync (parameter SYNC_STAGES, clk_dst, rst_dst, d, q) is the single-bit synchronizer. It is reused by the source-side ack synchronizer.
- Elaboration check: fatal if SYNC_STAGES<2 or SETTLE_CYCLES<1.

## Test plan
- Reset release, all inputs 0 → all outputs 0, busy 0 for 20 cycles.
- data_async=0xDEADBEEF, toggle req, data_ready=1 → data_valid for one cycle with data_out=0xDEADBEEF 4 to 5 edges after toggle; ack_tog 0→1 on the same edge.
- Same stimulus, data_ready=0 for 10 cycles → data_valid and data_out=0xDEADBEEF hold; ack_tog stays 0 (stays 1 under MCP_RX_EARLY_ACK_EN) until ready.
- Second req toggle one cycle after detection, before ack → err_protocol=1, sticky; second word delivered after first.
- Back-to-back: source toggles immediately on each ack with 0x1, 0x2, 0x3 → three words delivered in order, no loss, err_protocol=0.
- rst_dst asserted in SETTLE → outputs return to reset values asynchronously; no ack toggle; clean transfer after joint reset.
